// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer: entry type
// encodings, field widths, the run/squash state enum and type helpers.
package rob_pkg;

  localparam int REG_WIDTH      = 5;
  localparam int ROB_TYPE_WIDTH = 2;

  // bit0 = writes a register, bit1 = control transfer
  localparam logic [ROB_TYPE_WIDTH-1:0] TYPE_NONE   = 2'b00;  // store / no result
  localparam logic [ROB_TYPE_WIDTH-1:0] TYPE_ALU    = 2'b01;  // ALU or load
  localparam logic [ROB_TYPE_WIDTH-1:0] TYPE_BRANCH = 2'b10;  // conditional branch
  localparam logic [ROB_TYPE_WIDTH-1:0] TYPE_JALR   = 2'b11;  // indirect jump

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } rob_state_t;

  // Control transfers and stores close a commit group.
  function automatic logic ends_group(input logic [ROB_TYPE_WIDTH-1:0] t);
    return (t == TYPE_NONE) || t[1];
  endfunction

  // A branch mispredicts when its resolved direction differs from the
  // prediction; a JALR is always redirected.
  function automatic logic is_mispredict(input logic [ROB_TYPE_WIDTH-1:0] t,
                                         input logic predict,
                                         input logic res0);
    logic m;
    m = 1'b0;
    if (t == TYPE_BRANCH) m = (predict != res0);
    else if (t == TYPE_JALR) m = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Commit selection over the head window: builds the thermometer-coded
// cm_valid vector and reports whether the last committing slot redirects.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int SLOT_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic                               enable,
  input  logic [COMMIT_W-1:0]                win_present,
  input  logic [COMMIT_W-1:0]                win_done,
  input  logic [COMMIT_W-1:0]                win_predict,
  input  logic [COMMIT_W-1:0]                win_res0,
  input  logic [COMMIT_W*ROB_TYPE_WIDTH-1:0] win_type,
  output logic [COMMIT_W-1:0]                cm_valid,
  output logic                               mispredict,
  output logic [SLOT_W-1:0]                  mis_slot
);

  logic                      go;
  logic [ROB_TYPE_WIDTH-1:0] t;

  // Walk the window oldest-first; a slot commits only while every older
  // slot committed and none of them closed the group.
  always_comb begin
    cm_valid   = '0;
    mispredict = 1'b0;
    mis_slot   = '0;
    go         = enable;
    t          = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      t = win_type[i*ROB_TYPE_WIDTH +: ROB_TYPE_WIDTH];
      if (go && win_present[i] && win_done[i]) begin
        cm_valid[i] = 1'b1;
        mis_slot    = i[SLOT_W-1:0];
        mispredict  = is_mispredict(t, win_predict[i], win_res0[i]);
        go          = !ends_group(t);
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer retiring up to COMMIT_W entries per cycle in program order,
// with WB_PORTS writeback channels, operand lookups by ROB id and
// misprediction detection at commit followed by a squash state.
// Optional feature macro: ROB_BYPASS_EN (operand lookups also see same-cycle
// writebacks and a same-cycle completed dispatch).
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          dis_valid,
  output logic                          dis_ready,
  output logic [IDX_W-1:0]              dis_id,
  input  logic                          dis_done,
  input  logic [XLEN-1:0]               dis_res,
  input  logic [ROB_TYPE_WIDTH-1:0]     dis_type,
  input  logic [REG_WIDTH-1:0]          dis_dest,
  input  logic [XLEN-1:0]               dis_next_addr,
  input  logic [XLEN-1:0]               dis_jump_addr,
  input  logic                          dis_predict,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]     wb_id,
  input  logic [WB_PORTS*XLEN-1:0]      wb_data,
  input  logic [WB_PORTS-1:0]           wb_set_jump,
  input  logic [IDX_W-1:0]              q_id_j,
  input  logic [IDX_W-1:0]              q_id_k,
  output logic                          q_ready_j,
  output logic                          q_ready_k,
  output logic [XLEN-1:0]               q_data_j,
  output logic [XLEN-1:0]               q_data_k,
  output logic [COMMIT_W-1:0]           cm_valid,
  output logic [COMMIT_W*REG_WIDTH-1:0] cm_reg,
  output logic [COMMIT_W*XLEN-1:0]      cm_data,
  output logic [COMMIT_W*IDX_W-1:0]     cm_id,
  output logic                          flush_out,
  output logic [XLEN-1:0]               correct_pc,
  output logic [IDX_W-1:0]              head_id,
  output logic                          empty,
  output logic [IDX_W:0]                count
);

  localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  // control state
  logic [IDX_W-1:0] head_reg, tail_reg;
  logic [IDX_W:0]   count_reg, count_next;
  logic [DEPTH-1:0] present_reg, present_next;
  logic [DEPTH-1:0] done_reg, done_next;
  logic             flush_out_reg;
  logic [XLEN-1:0]  correct_pc_reg;
  rob_state_t       state_reg, state_next;

  // payload storage (never reset; validity lives in present/done)
  logic [ROB_TYPE_WIDTH-1:0] type_mem  [DEPTH];
  logic [REG_WIDTH-1:0]      dest_mem  [DEPTH];
  logic [XLEN-1:0]           res_mem   [DEPTH];
  logic [XLEN-1:0]           next_mem  [DEPTH];
  logic [XLEN-1:0]           jump_mem  [DEPTH];
  logic [DEPTH-1:0]          predict_mem;

  logic             dis_fire;
  logic             commit_en;
  logic [IDX_W:0]   commit_cnt;
  logic [IDX_W-1:0] wb_id_a   [WB_PORTS];
  logic [XLEN-1:0]  wb_data_a [WB_PORTS];
  logic [WB_PORTS-1:0] wb_hit;

  logic [IDX_W-1:0]                  win_idx [COMMIT_W];
  logic [COMMIT_W-1:0]               win_present, win_done, win_predict, win_res0;
  logic [COMMIT_W*ROB_TYPE_WIDTH-1:0] win_type;
  logic                              mispredict;
  logic [SLOT_W-1:0]                 mis_slot;
  logic [IDX_W-1:0]                  mis_idx;
  logic [XLEN-1:0]                   mis_target;

  assign dis_ready = (count_reg != (IDX_W+1)'(DEPTH)) && (state_reg == ST_RUN);
  assign dis_fire  = dis_valid && dis_ready && rdy_in;
  assign commit_en = rdy_in && (state_reg == ST_RUN);

  assign dis_id     = tail_reg;
  assign head_id    = head_reg;
  assign count      = count_reg;
  assign empty      = (count_reg == '0);
  assign flush_out  = flush_out_reg;
  assign correct_pc = correct_pc_reg;

  genvar gi;

  // unpack writeback channels; a hit needs a live target entry
  generate
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb
      assign wb_id_a[gi]   = wb_id[gi*IDX_W +: IDX_W];
      assign wb_data_a[gi] = wb_data[gi*XLEN +: XLEN];
      assign wb_hit[gi]    = rdy_in && wb_valid[gi] && present_reg[wb_id_a[gi]];
    end
  endgenerate

  // head window gather and per-slot commit outputs
  generate
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_win
      assign win_idx[gi]     = head_reg + IDX_W'(gi);
      assign win_present[gi] = present_reg[win_idx[gi]];
      assign win_done[gi]    = done_reg[win_idx[gi]];
      assign win_predict[gi] = predict_mem[win_idx[gi]];
      assign win_res0[gi]    = res_mem[win_idx[gi]][0];
      assign win_type[gi*ROB_TYPE_WIDTH +: ROB_TYPE_WIDTH] = type_mem[win_idx[gi]];

      assign cm_reg[gi*REG_WIDTH +: REG_WIDTH] =
        (cm_valid[gi] && type_mem[win_idx[gi]][0]) ? dest_mem[win_idx[gi]] : '0;
      assign cm_data[gi*XLEN +: XLEN] = cm_valid[gi] ? res_mem[win_idx[gi]] : '0;
      assign cm_id[gi*IDX_W +: IDX_W] = cm_valid[gi] ? win_idx[gi] : '0;
    end
  endgenerate

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .SLOT_W   (SLOT_W)
  ) u_select (
    .enable      (commit_en),
    .win_present (win_present),
    .win_done    (win_done),
    .win_predict (win_predict),
    .win_res0    (win_res0),
    .win_type    (win_type),
    .cm_valid    (cm_valid),
    .mispredict  (mispredict),
    .mis_slot    (mis_slot)
  );

  assign mis_idx    = win_idx[mis_slot];
  assign mis_target = predict_mem[mis_idx] ? next_mem[mis_idx] : jump_mem[mis_idx];

  // number of entries retiring this cycle
  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_cnt = commit_cnt + (IDX_W+1)'(cm_valid[i]);
    end
  end

  assign count_next = count_reg + (IDX_W+1)'(dis_fire) - commit_cnt;

  // next present/done bits: writeback sets done, commit retires, dispatch allocates
  always_comb begin
    present_next = present_reg;
    done_next    = done_reg;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_hit[p]) done_next[wb_id_a[p]] = 1'b1;
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (cm_valid[i]) begin
        present_next[win_idx[i]] = 1'b0;
        done_next[win_idx[i]]    = 1'b0;
      end
    end
    if (dis_fire) begin
      present_next[tail_reg] = 1'b1;
      done_next[tail_reg]    = dis_done;
    end
  end

  // run/squash next-state: squash after a redirecting commit until flushed
  always_comb begin
    state_next = state_reg;
    if (rdy_in) begin
      if (flush_in) state_next = ST_RUN;
      else if ((state_reg == ST_RUN) && mispredict) state_next = ST_SQUASH;
    end
  end

  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_reg <= ST_RUN;
    else         state_reg <= state_next;
  end

  // pointers, occupancy, entry flags and the redirect pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      present_reg    <= '0;
      done_reg       <= '0;
      flush_out_reg  <= 1'b0;
      correct_pc_reg <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_reg       <= '0;
        tail_reg       <= '0;
        count_reg      <= '0;
        present_reg    <= '0;
        done_reg       <= '0;
        flush_out_reg  <= 1'b0;
        correct_pc_reg <= '0;
      end else begin
        head_reg      <= head_reg + IDX_W'(commit_cnt);
        tail_reg      <= tail_reg + IDX_W'(dis_fire);
        count_reg     <= count_next;
        present_reg   <= present_next;
        done_reg      <= done_next;
        flush_out_reg <= mispredict;
        if (mispredict) correct_pc_reg <= mis_target;
      end
    end
  end

  // payload writes; later writeback channels override earlier ones
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      if (dis_fire) begin
        type_mem[tail_reg]    <= dis_type;
        dest_mem[tail_reg]    <= dis_dest;
        res_mem[tail_reg]     <= dis_res;
        next_mem[tail_reg]    <= dis_next_addr;
        jump_mem[tail_reg]    <= dis_jump_addr;
        predict_mem[tail_reg] <= dis_predict;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_hit[p]) begin
          if (wb_set_jump[p]) jump_mem[wb_id_a[p]] <= wb_data_a[p];
          else                res_mem[wb_id_a[p]]  <= wb_data_a[p];
        end
      end
    end
  end

  // operand lookup ports (j = 0, k = 1)
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic [IDX_W-1:0] qid;
      logic             rdy;
      logic [XLEN-1:0]  dat;

      assign qid = (gi == 0) ? q_id_j : q_id_k;

      // stored value, optionally overridden by same-cycle producers
      always_comb begin
        rdy = done_reg[qid];
        dat = done_reg[qid] ? res_mem[qid] : '0;
`ifdef ROB_BYPASS_EN
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_hit[p] && (wb_id_a[p] == qid)) begin
            rdy = 1'b1;
            dat = wb_set_jump[p] ? res_mem[qid] : wb_data_a[p];
          end
        end
        if (dis_fire && dis_done && (tail_reg == qid)) begin
          rdy = 1'b1;
          dat = dis_res;
        end
`endif
      end
    end
  endgenerate

  assign q_ready_j = g_lookup[0].rdy;
  assign q_data_j  = g_lookup[0].dat;
  assign q_ready_k = g_lookup[1].rdy;
  assign q_data_k  = g_lookup[1].dat;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit (DEPTH=16, COMMIT_W=2, WB_PORTS=2).
// Expected commit groups are queued when the stimulus that completes them
// is issued; a monitor compares every cycle in which cm_valid is non-zero.
module tb_rob_multi_commit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush_in = 1'b0;
  logic        dis_valid = 1'b0;
  logic        dis_ready;
  logic [3:0]  dis_id;
  logic        dis_done = 1'b0;
  logic [31:0] dis_res = '0;
  logic [1:0]  dis_type = '0;
  logic [4:0]  dis_dest = '0;
  logic [31:0] dis_next_addr = '0;
  logic [31:0] dis_jump_addr = '0;
  logic        dis_predict = 1'b0;
  logic [1:0]  wb_valid = '0;
  logic [7:0]  wb_id = '0;
  logic [63:0] wb_data = '0;
  logic [1:0]  wb_set_jump = '0;
  logic [3:0]  q_id_j = '0;
  logic [3:0]  q_id_k = '0;
  logic        q_ready_j, q_ready_k;
  logic [31:0] q_data_j, q_data_k;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_reg;
  logic [63:0] cm_data;
  logic [7:0]  cm_id;
  logic        flush_out;
  logic [31:0] correct_pc;
  logic [3:0]  head_id;
  logic        empty;
  logic [4:0]  count;

  always #5 clk = ~clk;

  rob_multi_commit dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush_in),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_id(dis_id),
    .dis_done(dis_done), .dis_res(dis_res), .dis_type(dis_type), .dis_dest(dis_dest),
    .dis_next_addr(dis_next_addr), .dis_jump_addr(dis_jump_addr), .dis_predict(dis_predict),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_set_jump(wb_set_jump),
    .q_id_j(q_id_j), .q_id_k(q_id_k), .q_ready_j(q_ready_j), .q_ready_k(q_ready_k),
    .q_data_j(q_data_j), .q_data_k(q_data_k),
    .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_data(cm_data), .cm_id(cm_id),
    .flush_out(flush_out), .correct_pc(correct_pc), .head_id(head_id),
    .empty(empty), .count(count)
  );

`ifdef ROB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic [1:0]  v;
    logic [3:0]  id0;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic [3:0]  id1;
    logic [4:0]  r1;
    logic [31:0] d1;
  } grp_t;

  grp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic push_grp(input logic [1:0] v,
                          input logic [3:0] id0, input logic [4:0] r0, input logic [31:0] d0,
                          input logic [3:0] id1, input logic [4:0] r1, input logic [31:0] d1);
    grp_t g;
    g.v = v; g.id0 = id0; g.r0 = r0; g.d0 = d0; g.id1 = id1; g.r1 = r1; g.d1 = d1;
    exp_q.push_back(g);
  endtask

  // commit monitor: one line per commit group, compared against the queue
  always @(negedge clk) begin
    grp_t g;
    if (rst_n && (cm_valid != 2'b00)) begin
      $display("commit v=%b id0=%0d reg0=%0d data0=0x%0h id1=%0d reg1=%0d data1=0x%0h",
               cm_valid, cm_id[3:0], cm_reg[4:0], cm_data[31:0], cm_id[7:4], cm_reg[9:5], cm_data[63:32]);
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'(cm_valid), 32'h0);
      end else begin
        g = exp_q.pop_front();
        check("cm_valid", 32'(cm_valid), 32'(g.v));
        check("cm_id0", 32'(cm_id[3:0]), 32'(g.id0));
        check("cm_reg0", 32'(cm_reg[4:0]), 32'(g.r0));
        check("cm_data0", cm_data[31:0], g.d0);
        if (g.v[1]) begin
          check("cm_id1", 32'(cm_id[7:4]), 32'(g.id1));
          check("cm_reg1", 32'(cm_reg[9:5]), 32'(g.r1));
          check("cm_data1", cm_data[63:32], g.d1);
        end
      end
    end
  end

  // two channels hitting the same id in one cycle is illegal stimulus
  always @(posedge clk) begin
    if (rst_n && (wb_valid == 2'b11))
      assert (wb_id[3:0] != wb_id[7:4]) else $error("illegal duplicate writeback id %0d", wb_id[3:0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dis_valid = 1'b0;
    wb_valid = '0;
    wb_set_jump = '0;
    flush_in = 1'b0;
  endtask

  task automatic dis(input logic [1:0] t, input logic done, input logic [4:0] dest,
                     input logic [31:0] res, input logic [31:0] nxt, input logic [31:0] jmp,
                     input logic pred);
    dis_valid = 1'b1; dis_type = t; dis_done = done; dis_dest = dest; dis_res = res;
    dis_next_addr = nxt; dis_jump_addr = jmp; dis_predict = pred;
    $display("dispatch id=%0d type=%b done=%b dest=%0d", dis_id, t, done, dest);
  endtask

  task automatic wbp(input int p, input logic [3:0] id, input logic [31:0] d);
    wb_valid[p] = 1'b1;
    wb_id[p*4 +: 4] = id;
    wb_data[p*32 +: 32] = d;
    wb_set_jump[p] = 1'b0;
    $display("writeback port=%0d id=%0d data=0x%0h", p, id, d);
  endtask

  initial begin
    idle();
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dis_ready", 32'(dis_ready), 32'h1);
    check("rst_cm_valid", 32'(cm_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_flush_out", 32'(flush_out), 32'h0);
    check("rst_correct_pc", correct_pc, 32'h0);
    check("rst_q_ready_j", 32'(q_ready_j), 32'h0);
    check("rst_q_data_j", q_data_j, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // fill all 16 entries, then complete them from the top down
    for (int i = 0; i < 16; i++) begin
      dis(2'b01, 1'b0, 5'(i + 1), 32'h0, 32'h0, 32'h0, 1'b0);
      cyc();
    end
    idle();
    @(negedge clk);
    check("full_dis_ready", 32'(dis_ready), 32'h0);
    check("full_count", 32'(count), 32'd16);
    for (int k = 0; k < 8; k++)
      push_grp(2'b11, 4'(2*k), 5'(2*k + 1), 32'h100 + 32'(2*k),
                      4'(2*k + 1), 5'(2*k + 2), 32'h101 + 32'(2*k));
    for (int k = 7; k >= 0; k--) begin
      idle();
      wbp(0, 4'(2*k), 32'h100 + 32'(2*k));
      wbp(1, 4'(2*k + 1), 32'h101 + 32'(2*k));
      cyc();
    end
    idle();
    @(negedge clk);
    check("commit_cycle_dis_ready", 32'(dis_ready), 32'h0);
    check("commit_cycle_count", 32'(count), 32'd16);
    cyc();
    @(negedge clk);
    check("after_commit_dis_ready", 32'(dis_ready), 32'h1);
    check("after_commit_count", 32'(count), 32'd14);
    repeat (7) cyc();
    @(negedge clk);
    check("wrap_count", 32'(count), 32'h0);
    check("wrap_head", 32'(head_id), 32'h0);
    check("wrap_dis_id", 32'(dis_id), 32'h0);

    // mispredicted branch at id 0 followed by a completed ALU op
    dis(2'b10, 1'b0, 5'd0, 32'h0, 32'h104, 32'h200, 1'b1);
    cyc();
    dis(2'b01, 1'b1, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0);
    cyc();
    idle();
    wbp(0, 4'd0, 32'h0);
    push_grp(2'b01, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    check("br_commit_flush_out", 32'(flush_out), 32'h0);
    cyc();
    @(negedge clk);
    check("br_flush_out", 32'(flush_out), 32'h1);
    check("br_correct_pc", correct_pc, 32'h104);
    check("br_squash_dis_ready", 32'(dis_ready), 32'h0);
    check("br_squash_count", 32'(count), 32'h1);
    cyc();
    @(negedge clk);
    check("br_flush_pulse_end", 32'(flush_out), 32'h0);
    check("br_squash_hold", 32'(dis_ready), 32'h0);
    flush_in = 1'b1;
    cyc();
    idle();
    @(negedge clk);
    check("flush_count", 32'(count), 32'h0);
    check("flush_dis_ready", 32'(dis_ready), 32'h1);
    check("flush_correct_pc", correct_pc, 32'h0);
    check("flush_head", 32'(head_id), 32'h0);

    // out-of-order writeback on two ports, plus a lookup of id 1
    dis(2'b01, 1'b0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    dis(2'b01, 1'b0, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    idle();
    wbp(1, 4'd1, 32'h55);
    q_id_j = 4'd1;
    @(negedge clk);
    check("wb_sameclk_q_ready_j", 32'(q_ready_j), 32'(BYP));
    cyc();
    wb_valid = '0;
    wbp(0, 4'd0, 32'hAA);
    push_grp(2'b11, 4'd0, 5'd3, 32'hAA, 4'd1, 5'd4, 32'h55);
    @(negedge clk);
    check("wb_next_q_ready_j", 32'(q_ready_j), 32'h1);
    check("wb_next_q_data_j", q_data_j, 32'h55);
    cyc();
    idle();
    @(negedge clk);
    check("pair_commit_count", 32'(count), 32'h2);
    cyc();
    @(negedge clk);
    check("pair_after_count", 32'(count), 32'h0);

    // store then ALU, both done: store ends its group
    dis(2'b00, 1'b0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    dis(2'b01, 1'b1, 5'd8, 32'h33, 32'h0, 32'h0, 1'b0);
    cyc();
    idle();
    wbp(1, 4'd2, 32'h22);
    push_grp(2'b01, 4'd2, 5'd0, 32'h22, 4'd0, 5'd0, 32'h0);
    push_grp(2'b01, 4'd3, 5'd8, 32'h33, 4'd0, 5'd0, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    check("store_commit_count", 32'(count), 32'h2);
    cyc();
    @(negedge clk);
    check("alu_commit_count", 32'(count), 32'h1);
    cyc();
    @(negedge clk);
    check("store_alu_empty", 32'(empty), 32'h1);

    // rdy_in low freezes a committable head
    dis(2'b01, 1'b1, 5'd10, 32'h44, 32'h0, 32'h0, 1'b0);
    cyc();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_cm_valid", 32'(cm_valid), 32'h0);
      check("stall_count", 32'(count), 32'h1);
      cyc();
    end
    rdy = 1'b1;
    push_grp(2'b01, 4'd4, 5'd10, 32'h44, 4'd0, 5'd0, 32'h0);
    cyc();
    @(negedge clk);
    check("stall_release_empty", 32'(empty), 32'h1);

    // writeback to id 5 with a same-cycle lookup
    dis(2'b01, 1'b0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    idle();
    wbp(0, 4'd5, 32'h1234);
    q_id_j = 4'd5;
    push_grp(2'b01, 4'd5, 5'd11, 32'h1234, 4'd0, 5'd0, 32'h0);
    @(negedge clk);
    check("byp_q_ready_j", 32'(q_ready_j), 32'(BYP));
    check("byp_q_data_j", q_data_j, BYP ? 32'h1234 : 32'h0);
    cyc();
    idle();
    @(negedge clk);
    check("late_q_ready_j", 32'(q_ready_j), 32'h1);
    check("late_q_data_j", q_data_j, 32'h1234);
    cyc();
    @(negedge clk);
    check("final_empty", 32'(empty), 32'h1);
    repeat (2) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
